apb_addr_demux: RTL and testbench
=================================

Name: apb_addr_demux

Overview:
- APB (v2/v3-style) 1-to-N demultiplexer with a built-in equal-region address decoder.
- One APB completer-side port fans out to NoMstPorts requester-side ports.
- The target port is chosen from PADDR during the setup phase and held for the whole transfer.
- Sits between an APB bridge and a group of peripherals.

Parameters:
- AddrWidth, 15, PADDR width in bits.
- DataWidth, 32, PWDATA/PRDATA width in bits. Must be a multiple of 8.
- NoMstPorts, 5, number of downstream ports. Must be ≥ 2.
- StrbWidth, DataWidth/8, PSTRB width (derived, not overridable).
- SelWidth, $clog2(NoMstPorts), select width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- slv_paddr_i  in  AddrWidth  upstream address
- slv_pprot_i  in  3  upstream protection
- slv_psel_i  in  1  upstream select
- slv_penable_i  in  1  upstream enable
- slv_pwrite_i  in  1  upstream write
- slv_pwdata_i  in  DataWidth  upstream write data
- slv_pstrb_i  in  StrbWidth  upstream byte strobes
- slv_pready_o  out  1  upstream ready
- slv_prdata_o  out  DataWidth  upstream read data
- slv_pslverr_o  out  1  upstream error
- mst_paddr_o  out  AddrWidth  broadcast address
- mst_pprot_o  out  3  broadcast protection
- mst_psel_o  out  NoMstPorts  one-hot per-port select
- mst_penable_o  out  1  broadcast enable
- mst_pwrite_o  out  1  broadcast write
- mst_pwdata_o  out  DataWidth  broadcast write data
- mst_pstrb_o  out  StrbWidth  broadcast strobes
- mst_pready_i  in  NoMstPorts  per-port ready
- mst_prdata_i  in  NoMstPorts*DataWidth  per-port read data; port i occupies bits [i*DataWidth +: DataWidth]
- mst_pslverr_i  in  NoMstPorts  per-port error
- sel_o  out  SelWidth  port index currently in effect

Behaviour:

Address decode (combinational):
- RegionSize = 2**AddrWidth / NoMstPorts, integer floor.
- Port i owns the half-open range [i*RegionSize, (i+1)*RegionSize).
- Addresses ≥ NoMstPorts*RegionSize decode to default port 0. These are the tail left by the floor division. No decode error is raised.

Select register sel_q:
- Reset value 0.
- On a clock edge with slv_psel_i=1 and slv_penable_i=0 (setup phase): sel_q <= decoded index.
- Otherwise sel_q holds its value.

Effective select:
- Setup phase (psel=1, penable=0): the decoded index.
- All other times: sel_q.
- sel_o always shows the effective select.
- Consequence: a PADDR change during the access phase does not re-route the transfer.

Request path (combinational, zero latency):
- paddr, pprot, penable, pwrite, pwdata, pstrb are broadcast unchanged to all ports.
- mst_psel_o[sel] = slv_psel_i; every other bit is 0.
- When slv_psel_i=0, mst_psel_o = 0.

Response path (combinational):
- When slv_psel_i=1: slv_pready_o, slv_prdata_o and slv_pslverr_o come from the selected port.
- When slv_psel_i=0: all three response outputs are 0.
- A transfer completes on the edge where psel=penable=pready=1. The demux adds no wait states.
- The PSLVERR and PRDATA values are forwarded as-is. They are meaningful only when pready=1; no masking is applied.

Back-to-back transfers:
- A new setup phase immediately after completion re-decodes the address.
- Consecutive transfers to different ports therefore work with no idle cycle.

Reset:
- Assertion of rst_i mid-transfer forces sel_q=0 asynchronously.
- Combinational outputs keep following their inputs.

Other rules:
- Stateless apart from sel_q. No buffering, no reordering.
- Each port's pready/prdata/pslverr is ignored unless that port is selected.

Test Plan (defaults: RegionSize=6553):
1. Write to paddr=0x0000, pwdata=0xDEADBEEF, pstrb=0xF -> only mst_psel_o[0]=1. Port 0 sees identical addr/data/strb. Completion follows port 0's pready after 3 wait states.
2. Reads at paddr=6552, 6553 and 26212 -> routed to ports 0, 1 and 4 respectively. Each port returns a distinct prdata (e.g. 0x11111111 for port 0) and slv_prdata_o matches it. pslverr=1 from port 4 propagates to slv_pslverr_o.
3. Read at paddr=0x7FFE, which is unmapped -> routed to default port 0 and sel_o=0.
4. Setup at paddr=6553 (port 1), then paddr changed to 0 during the access phase with pready held low -> mst_psel_o stays 0b00010 until completion.
5. Back-to-back transfers to ports 2, 3 and 2 with no idle cycle -> each completes on its own port. An unselected port driving pready=1 never completes the upstream transfer.
6. Random run of 1000 transfers with random wait states (0–5 cycles) -> every request arrives exactly once at the expected port, read data and pslverr match, and no request is lost. Additionally, assert rst_i mid-access -> sel_o returns to 0.

Source files
------------

// File: rtl/apb_addr_demux.sv
// apb_addr_demux: APB 1-to-N demux with an equal-region address decoder.
// The port chosen in setup is latched so that PADDR changes in the access phase cannot re-route.
module apb_addr_demux #(
    parameter int unsigned AddrWidth  = 15,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NoMstPorts = 5,
    localparam int unsigned StrbWidth = DataWidth / 8,
    localparam int unsigned SelWidth  = $clog2(NoMstPorts)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [AddrWidth-1:0]           slv_paddr_i,
    input  logic [2:0]                     slv_pprot_i,
    input  logic                           slv_psel_i,
    input  logic                           slv_penable_i,
    input  logic                           slv_pwrite_i,
    input  logic [DataWidth-1:0]           slv_pwdata_i,
    input  logic [StrbWidth-1:0]           slv_pstrb_i,
    output logic                           slv_pready_o,
    output logic [DataWidth-1:0]           slv_prdata_o,
    output logic                           slv_pslverr_o,
    output logic [AddrWidth-1:0]           mst_paddr_o,
    output logic [2:0]                     mst_pprot_o,
    output logic [NoMstPorts-1:0]          mst_psel_o,
    output logic                           mst_penable_o,
    output logic                           mst_pwrite_o,
    output logic [DataWidth-1:0]           mst_pwdata_o,
    output logic [StrbWidth-1:0]           mst_pstrb_o,
    input  logic [NoMstPorts-1:0]          mst_pready_i,
    input  logic [NoMstPorts*DataWidth-1:0] mst_prdata_i,
    input  logic [NoMstPorts-1:0]          mst_pslverr_i,
    output logic [SelWidth-1:0]            sel_o
);
    localparam logic [AddrWidth:0] RegionSize =
        (AddrWidth + 1)'((64'd1 << AddrWidth) / 64'(NoMstPorts));

    if (NoMstPorts < 2 || DataWidth % 8 != 0) begin : g_bad_params
        $error("apb_addr_demux: NoMstPorts must be >= 2 and DataWidth a multiple of 8");
    end

    logic [SelWidth-1:0]  sel_q, sel_d, dec_idx;
    logic                 setup;
    logic [DataWidth-1:0] rdata [NoMstPorts];

    // Tail addresses beyond the last full region match nothing and fall back to port 0.
    always_comb begin
        dec_idx = '0;
        for (int i = 0; i < NoMstPorts; i++)
            if ({1'b0, slv_paddr_i} >= RegionSize * (AddrWidth + 1)'(i) &&
                {1'b0, slv_paddr_i} <  RegionSize * (AddrWidth + 1)'(i + 1))
                dec_idx = SelWidth'(i);
    end

    assign setup = slv_psel_i & ~slv_penable_i;
    assign sel_d = setup ? dec_idx : sel_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sel_q <= '0;
        else       sel_q <= sel_d;
    end

    for (genvar g = 0; g < NoMstPorts; g++) begin : g_rdata
        assign rdata[g] = mst_prdata_i[g*DataWidth +: DataWidth];
    end

    assign sel_o         = sel_d;
    assign mst_paddr_o   = slv_paddr_i;
    assign mst_pprot_o   = slv_pprot_i;
    assign mst_penable_o = slv_penable_i;
    assign mst_pwrite_o  = slv_pwrite_i;
    assign mst_pwdata_o  = slv_pwdata_i;
    assign mst_pstrb_o   = slv_pstrb_i;
    assign mst_psel_o    = slv_psel_i ? NoMstPorts'(1) << sel_d : '0;
    assign slv_pready_o  = slv_psel_i & mst_pready_i[sel_d];
    assign slv_pslverr_o = slv_psel_i & mst_pslverr_i[sel_d];
    assign slv_prdata_o  = slv_psel_i ? rdata[sel_d] : '0;
endmodule

// File: tb/tb_apb_addr_demux.sv
// tb_apb_addr_demux: directed table, corner sequences and random traffic against a region-arithmetic model.
module tb_apb_addr_demux;
    localparam int AW = 15, DW = 32, NP = 5, SW = 3, RS = 6553;

    logic              clk = 1'b0, rst;
    logic [AW-1:0]     paddr;
    logic [2:0]        pprot;
    logic              psel, penable, pwrite;
    logic [DW-1:0]     pwdata;
    logic [DW/8-1:0]   pstrb;
    logic              slv_pready_o, slv_pslverr_o;
    logic [DW-1:0]     slv_prdata_o;
    logic [AW-1:0]     mst_paddr_o;
    logic [2:0]        mst_pprot_o;
    logic [NP-1:0]     mst_psel_o;
    logic              mst_penable_o, mst_pwrite_o;
    logic [DW-1:0]     mst_pwdata_o;
    logic [DW/8-1:0]   mst_pstrb_o;
    logic [NP-1:0]     mst_pready_i, mst_pslverr_i;
    logic [NP*DW-1:0]  mst_prdata_i;
    logic [SW-1:0]     sel_o;

    logic [DW-1:0]     rd [NP];
    int                n_chk = 0, n_fail = 0;
    int                exp_cnt [NP] = '{default: 0};
    int                got_cnt [NP] = '{default: 0};

    typedef struct { int addr; int port; } vec_t;
    vec_t tbl [12];

    apb_addr_demux dut (
        .clk_i(clk), .rst_i(rst),
        .slv_paddr_i(paddr), .slv_pprot_i(pprot), .slv_psel_i(psel), .slv_penable_i(penable),
        .slv_pwrite_i(pwrite), .slv_pwdata_i(pwdata), .slv_pstrb_i(pstrb),
        .slv_pready_o(slv_pready_o), .slv_prdata_o(slv_prdata_o), .slv_pslverr_o(slv_pslverr_o),
        .mst_paddr_o(mst_paddr_o), .mst_pprot_o(mst_pprot_o), .mst_psel_o(mst_psel_o),
        .mst_penable_o(mst_penable_o), .mst_pwrite_o(mst_pwrite_o), .mst_pwdata_o(mst_pwdata_o),
        .mst_pstrb_o(mst_pstrb_o), .mst_pready_i(mst_pready_i), .mst_prdata_i(mst_prdata_i),
        .mst_pslverr_i(mst_pslverr_i), .sel_o(sel_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int i = 0; i < NP; i++)
            if (mst_psel_o[i] && mst_penable_o && mst_pready_i[i]) got_cnt[i]++;

    function automatic int ref_port(input int a);
        return (a < NP * RS) ? a / RS : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_rd();
        for (int i = 0; i < NP; i++) mst_prdata_i[i*DW +: DW] = rd[i];
    endtask

    // Entered and left at posedge+1; no idle cycle is inserted between calls.
    task automatic xfer(input int addr, input int acc_addr, input int port, input bit wr,
                        input logic [DW-1:0] wd, input logic [3:0] st, input int waits);
        logic [2:0] prot;
        prot = 3'($urandom);
        exp_cnt[port]++;
        drive_rd();
        psel = 1; penable = 0; paddr = AW'(addr); pwrite = wr; pwdata = wd; pstrb = st; pprot = prot;
        mst_pready_i = NP'($urandom);
        #4;
        chk("setup_sel_o", sel_o, port);
        chk("setup_psel", mst_psel_o, 64'd1 << port);
        chk("bcast_addr", mst_paddr_o, addr);
        chk("bcast_wdata", mst_pwdata_o, wd);
        chk("bcast_strb", mst_pstrb_o, st);
        chk("bcast_write", mst_pwrite_o, wr);
        chk("bcast_prot", mst_pprot_o, prot);
        chk("bcast_penable_setup", mst_penable_o, 0);
        @(posedge clk); #1;
        penable = 1; paddr = AW'(acc_addr);
        for (int w = 0; w <= waits; w++) begin
            mst_pready_i = (w == waits) ? '1 : NP'($urandom) & ~(NP'(1) << port);
            #4;
            chk("acc_psel", mst_psel_o, 64'd1 << port);
            chk("acc_sel_o", sel_o, port);
            chk("acc_ready", slv_pready_o, w == waits);
            if (w == waits) begin
                chk("rdata", slv_prdata_o, rd[port]);
                chk("pslverr", slv_pslverr_o, mst_pslverr_i[port]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        psel = 0; penable = 0; mst_pready_i = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; psel = 0; penable = 0; paddr = '0; pprot = '0; pwrite = 0; pwdata = '0; pstrb = '0;
        mst_pready_i = '1; mst_pslverr_i = '1;
        for (int i = 0; i < NP; i++) rd[i] = {8{4'(i + 1)}};
        drive_rd();
        #3;
        chk("rst_sel_o", sel_o, 0);
        chk("idle_psel", mst_psel_o, 0);
        chk("idle_ready", slv_pready_o, 0);
        chk("idle_rdata", slv_prdata_o, 0);
        chk("idle_err", slv_pslverr_o, 0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        mst_pslverr_i = '0;
        xfer(0, 0, 0, 1, 32'hDEADBEEF, 4'hF, 3);
        idle();

        tbl = '{'{0, 0}, '{6552, 0}, '{6553, 1}, '{13105, 1}, '{13106, 2}, '{19659, 3},
                '{26211, 3}, '{26212, 4}, '{32764, 4}, '{32765, 0}, '{32766, 0}, '{32767, 0}};
        mst_pslverr_i = 5'b10000;
        for (int k = 0; k < 12; k++) begin
            xfer(tbl[k].addr, tbl[k].addr, tbl[k].port, 0, '0, '0, k % 3);
            idle();
        end

        mst_pslverr_i = '0;
        xfer(6553, 0, 1, 0, '0, '0, 4);
        xfer(13106, 13106, 2, 1, 32'h2222_0000, 4'h3, 0);
        xfer(19659, 19659, 3, 0, '0, '0, 2);
        xfer(13200, 13200, 2, 1, 32'h2222_0001, 4'hC, 1);
        idle();

        psel = 1; penable = 0; paddr = AW'(19659); mst_pready_i = '0;
        @(posedge clk); #1;
        penable = 1;
        #1;
        chk("pre_rst_sel_o", sel_o, 3);
        rst = 1;
        #1;
        chk("mid_rst_sel_o", sel_o, 0);
        chk("mid_rst_psel", mst_psel_o, 1);
        idle();
        rst = 0;
        @(posedge clk); #1;

        for (int n = 0; n < 1000; n++) begin
            int a;
            a = int'($urandom_range(0, 32767));
            for (int i = 0; i < NP; i++) rd[i] = $urandom;
            mst_pslverr_i = NP'($urandom);
            xfer(a, int'($urandom_range(0, 32767)), ref_port(a), 1'($urandom),
                 $urandom, 4'($urandom), int'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        for (int i = 0; i < NP; i++) chk($sformatf("arrivals_port%0d", i), got_cnt[i], exp_cnt[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
